// File: rtl/ooo_pkg.sv
// Shared out-of-order core definitions: ROB geometry defaults and entry state encodings.
package ooo_pkg;

  localparam int unsigned ROB_SIZE_DFLT     = 8;
  localparam int unsigned ROB_SIZE_LOG_DFLT = 3;
  localparam int unsigned MEM_LAT_DFLT      = 2;

  typedef enum logic [1:0] {
    RobIdle     = 2'd0,
    RobStalled  = 2'd1,
    RobReady    = 2'd2,
    RobFinished = 2'd3
  } rob_state_e;

endpackage

// File: rtl/age_picker.sv
// Oldest-first picker: rotate the request vector so the head sits at bit 0, then take the
// lowest set bit and rotate the result back into ROB index space.
module age_picker #(
  parameter int unsigned N = 8,
  parameter int unsigned W = 3
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] head,
  output logic         valid,
  output logic [W-1:0] idx
);

  logic [N-1:0] rot;
  logic [W-1:0] off;

  // Rotate by head, priority-encode by age, map the age back to an entry index.
  always_comb begin
    rot = '0;
    for (int j = 0; j < N; j++) begin
      rot[j] = req[W'(j) + head];
    end
    off = '0;
    for (int j = N - 1; j >= 0; j--) begin
      if (rot[j]) off = W'(j);
    end
    valid = |req;
    idx   = valid ? (off + head) : '0;
  end

endmodule

// File: rtl/rob_issue_sched.sv
// Issue scheduler: arbitrates READY ROB entries onto one single-cycle ALU and one pipelined
// memory read port, oldest-first, and returns writeback strobes for in-flight entries.
module rob_issue_sched #(
  parameter int unsigned ROB_SIZE     = ooo_pkg::ROB_SIZE_DFLT,
  parameter int unsigned ROB_SIZE_LOG = ooo_pkg::ROB_SIZE_LOG_DFLT,
  parameter int unsigned MEM_LAT      = ooo_pkg::MEM_LAT_DFLT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    squash,
  input  logic [ROB_SIZE_LOG-1:0] rob_head,
  input  logic [ROB_SIZE-1:0]     ready_vec,
  input  logic [ROB_SIZE-1:0]     is_mem_vec,
  input  logic                    mem_port_busy,
  output logic                    alu_issue_valid,
  output logic [ROB_SIZE_LOG-1:0] alu_issue_idx,
  output logic                    mem_issue_valid,
  output logic [ROB_SIZE_LOG-1:0] mem_issue_idx,
  output logic                    alu_wb_valid,
  output logic [ROB_SIZE_LOG-1:0] alu_wb_idx,
  output logic                    mem_wb_valid,
  output logic [ROB_SIZE_LOG-1:0] mem_wb_idx,
  output logic [ROB_SIZE_LOG:0]   inflight_cnt
);

  import ooo_pkg::*;

  localparam int unsigned CW = ROB_SIZE_LOG + 1;

  logic [ROB_SIZE-1:0]     issued_q, issued_d;
  logic                    alu_wb_v_q, alu_wb_v_d;
  logic [ROB_SIZE_LOG-1:0] alu_wb_i_q, alu_wb_i_d;
  logic [MEM_LAT-1:0]      mem_v_q, mem_v_d;
  logic [ROB_SIZE_LOG-1:0] mem_i_q [MEM_LAT];
  logic [ROB_SIZE_LOG-1:0] mem_i_d [MEM_LAT];
  logic [CW-1:0]           inflight_q, inflight_d;

  logic [ROB_SIZE-1:0]     alu_cand, mem_cand;
  logic                    alu_pick_v, mem_pick_v;
  logic [ROB_SIZE_LOG-1:0] alu_pick_i, mem_pick_i;
  logic                    kill;

  assign alu_cand = ready_vec & ~issued_q & ~is_mem_vec;
  assign mem_cand = ready_vec & ~issued_q & is_mem_vec;
  // A reset cycle behaves like a squash cycle: nothing issues, everything flushes.
  assign kill     = squash | rst;

  age_picker #(.N(ROB_SIZE), .W(ROB_SIZE_LOG)) u_alu_pick (
    .req   (alu_cand),
    .head  (rob_head),
    .valid (alu_pick_v),
    .idx   (alu_pick_i)
  );

  age_picker #(.N(ROB_SIZE), .W(ROB_SIZE_LOG)) u_mem_pick (
    .req   (mem_cand),
    .head  (rob_head),
    .valid (mem_pick_v),
    .idx   (mem_pick_i)
  );

  // Issue decisions; idx outputs are forced to 0 whenever no issue happens.
  always_comb begin
    alu_issue_valid = alu_pick_v & ~kill;
    mem_issue_valid = mem_pick_v & ~kill & ~mem_port_busy;
    alu_issue_idx   = alu_issue_valid ? alu_pick_i : '0;
    mem_issue_idx   = mem_issue_valid ? mem_pick_i : '0;
  end

  assign alu_wb_valid = alu_wb_v_q;
  assign alu_wb_idx   = alu_wb_i_q;
  assign mem_wb_valid = mem_v_q[MEM_LAT-1];
  assign mem_wb_idx   = mem_i_q[MEM_LAT-1];
  assign inflight_cnt = inflight_q;

  // Next state: writeback clears first, then issue sets so a same-index collision keeps the set.
  always_comb begin
    issued_d = issued_q;
    if (alu_wb_v_q)          issued_d[alu_wb_i_q]         = 1'b0;
    if (mem_v_q[MEM_LAT-1])  issued_d[mem_i_q[MEM_LAT-1]] = 1'b0;
    if (alu_issue_valid)     issued_d[alu_issue_idx]      = 1'b1;
    if (mem_issue_valid)     issued_d[mem_issue_idx]      = 1'b1;

    alu_wb_v_d = alu_issue_valid;
    alu_wb_i_d = alu_issue_idx;

    mem_v_d[0] = mem_issue_valid;
    mem_i_d[0] = mem_issue_idx;
    for (int k = 1; k < MEM_LAT; k++) begin
      mem_v_d[k] = mem_v_q[k-1];
      mem_i_d[k] = mem_i_q[k-1];
    end

    inflight_d = inflight_q + CW'(alu_issue_valid) + CW'(mem_issue_valid)
                 - CW'(alu_wb_v_q) - CW'(mem_v_q[MEM_LAT-1]);

    if (kill) begin
      issued_d   = '0;
      alu_wb_v_d = 1'b0;
      alu_wb_i_d = '0;
      mem_v_d    = '0;
      for (int k = 0; k < MEM_LAT; k++) mem_i_d[k] = '0;
      inflight_d = '0;
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      issued_q   <= '0;
      alu_wb_v_q <= 1'b0;
      alu_wb_i_q <= '0;
      mem_v_q    <= '0;
      mem_i_q    <= '{default: '0};
      inflight_q <= '0;
    end else begin
      issued_q   <= issued_d;
      alu_wb_v_q <= alu_wb_v_d;
      alu_wb_i_q <= alu_wb_i_d;
      mem_v_q    <= mem_v_d;
      mem_i_q    <= mem_i_d;
      inflight_q <= inflight_d;
    end
  end

endmodule

// File: tb/tb_rob_issue_sched.sv
// Directed bench for rob_issue_sched with hand-computed expectations (MEM_LAT = 2).
module tb_rob_issue_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       squash;
  logic [2:0] rob_head;
  logic [7:0] ready_vec;
  logic [7:0] is_mem_vec;
  logic       mem_port_busy;
  logic       alu_issue_valid, mem_issue_valid, alu_wb_valid, mem_wb_valid;
  logic [2:0] alu_issue_idx, mem_issue_idx, alu_wb_idx, mem_wb_idx;
  logic [3:0] inflight_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rob_issue_sched #(.ROB_SIZE(8), .ROB_SIZE_LOG(3), .MEM_LAT(2)) dut (
    .clk             (clk),
    .rst             (rst),
    .squash          (squash),
    .rob_head        (rob_head),
    .ready_vec       (ready_vec),
    .is_mem_vec      (is_mem_vec),
    .mem_port_busy   (mem_port_busy),
    .alu_issue_valid (alu_issue_valid),
    .alu_issue_idx   (alu_issue_idx),
    .mem_issue_valid (mem_issue_valid),
    .mem_issue_idx   (mem_issue_idx),
    .alu_wb_valid    (alu_wb_valid),
    .alu_wb_idx      (alu_wb_idx),
    .mem_wb_valid    (mem_wb_valid),
    .mem_wb_idx      (mem_wb_idx),
    .inflight_cnt    (inflight_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Start a new cycle: advance past the edge, apply inputs, let combinational outputs settle.
  task automatic cyc(input logic [7:0] rv, input logic [7:0] mv, input logic busy,
                     input logic sq);
    @(posedge clk);
    #1;
    ready_vec     = rv;
    is_mem_vec    = mv;
    mem_port_busy = busy;
    squash        = sq;
    #1;
  endtask

  task automatic chk_alu(input string tag, input logic iv, input logic [2:0] ii,
                         input logic wv, input logic [2:0] wi);
    check({tag, ".alu_iv"}, alu_issue_valid, iv);
    check({tag, ".alu_ii"}, alu_issue_idx, ii);
    check({tag, ".alu_wv"}, alu_wb_valid, wv);
    check({tag, ".alu_wi"}, alu_wb_idx, wi);
  endtask

  task automatic chk_mem(input string tag, input logic iv, input logic [2:0] ii,
                         input logic wv, input logic [2:0] wi);
    check({tag, ".mem_iv"}, mem_issue_valid, iv);
    check({tag, ".mem_ii"}, mem_issue_idx, ii);
    check({tag, ".mem_wv"}, mem_wb_valid, wv);
    check({tag, ".mem_wi"}, mem_wb_idx, wi);
  endtask

  initial begin
    rst = 1'b1; squash = 1'b0; rob_head = 3'd0;
    ready_vec = '0; is_mem_vec = '0; mem_port_busy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    // Reset state.
    chk_alu("rst", 1'b0, 3'd0, 1'b0, 3'd0);
    chk_mem("rst", 1'b0, 3'd0, 1'b0, 3'd0);
    check("rst.cnt", inflight_cnt, 4'd0);

    // ALU back-to-back, head 0, entries 1 and 2.
    cyc(8'b0000_0110, 8'h00, 1'b0, 1'b0);
    chk_alu("a0", 1'b1, 3'd1, 1'b0, 3'd0);
    check("a0.cnt", inflight_cnt, 4'd0);
    cyc(8'b0000_0110, 8'h00, 1'b0, 1'b0);
    chk_alu("a1", 1'b1, 3'd2, 1'b1, 3'd1);
    check("a1.cnt", inflight_cnt, 4'd1);
    cyc(8'b0000_0100, 8'h00, 1'b0, 1'b0);
    chk_alu("a2", 1'b0, 3'd0, 1'b1, 3'd2);
    check("a2.cnt", inflight_cnt, 4'd1);
    cyc(8'h00, 8'h00, 1'b0, 1'b0);
    chk_alu("a3", 1'b0, 3'd0, 1'b0, 3'd0);
    check("a3.cnt", inflight_cnt, 4'd0);

    // Wrap-around: head 6, candidates 1 and 7; 7 is older.
    rob_head = 3'd6;
    cyc(8'b1000_0010, 8'h00, 1'b0, 1'b0);
    chk_alu("w0", 1'b1, 3'd7, 1'b0, 3'd0);
    cyc(8'b1000_0010, 8'h00, 1'b0, 1'b0);
    chk_alu("w1", 1'b1, 3'd1, 1'b1, 3'd7);
    cyc(8'b0000_0010, 8'h00, 1'b0, 1'b0);
    chk_alu("w2", 1'b0, 3'd0, 1'b1, 3'd1);
    cyc(8'h00, 8'h00, 1'b0, 1'b0);
    check("w3.cnt", inflight_cnt, 4'd0);

    // Memory pipeline, head 0, mem entries 3 and 4.
    rob_head = 3'd0;
    cyc(8'b0001_1000, 8'b0001_1000, 1'b0, 1'b0);
    chk_mem("m0", 1'b1, 3'd3, 1'b0, 3'd0);
    check("m0.alu_iv", alu_issue_valid, 1'b0);
    cyc(8'b0001_1000, 8'b0001_1000, 1'b0, 1'b0);
    chk_mem("m1", 1'b1, 3'd4, 1'b0, 3'd0);
    check("m1.cnt", inflight_cnt, 4'd1);
    cyc(8'b0001_1000, 8'b0001_1000, 1'b0, 1'b0);
    chk_mem("m2", 1'b0, 3'd0, 1'b1, 3'd3);
    check("m2.cnt", inflight_cnt, 4'd2);
    cyc(8'b0001_0000, 8'b0001_1000, 1'b0, 1'b0);
    chk_mem("m3", 1'b0, 3'd0, 1'b1, 3'd4);
    check("m3.cnt", inflight_cnt, 4'd1);
    cyc(8'h00, 8'h00, 1'b0, 1'b0);
    chk_mem("m4", 1'b0, 3'd0, 1'b0, 3'd0);
    check("m4.cnt", inflight_cnt, 4'd0);

    // Mixed: ALU entry 2 and mem entry 5 issue together.
    cyc(8'b0010_0100, 8'b0010_0000, 1'b0, 1'b0);
    chk_alu("x0", 1'b1, 3'd2, 1'b0, 3'd0);
    chk_mem("x0", 1'b1, 3'd5, 1'b0, 3'd0);
    cyc(8'b0010_0100, 8'b0010_0000, 1'b0, 1'b0);
    chk_alu("x1", 1'b0, 3'd0, 1'b1, 3'd2);
    check("x1.mem_wv", mem_wb_valid, 1'b0);
    check("x1.cnt", inflight_cnt, 4'd2);
    cyc(8'b0010_0000, 8'b0010_0000, 1'b0, 1'b0);
    check("x2.alu_wv", alu_wb_valid, 1'b0);
    chk_mem("x2", 1'b0, 3'd0, 1'b1, 3'd5);
    check("x2.cnt", inflight_cnt, 4'd1);
    cyc(8'h00, 8'h00, 1'b0, 1'b0);
    check("x3.cnt", inflight_cnt, 4'd0);

    // mem_port_busy holds off mem entry 0 for three cycles.
    for (int i = 0; i < 3; i++) begin
      cyc(8'b0000_0001, 8'b0000_0001, 1'b1, 1'b0);
      check("b.hold_iv", mem_issue_valid, 1'b0);
    end
    cyc(8'b0000_0001, 8'b0000_0001, 1'b0, 1'b0);
    chk_mem("b3", 1'b1, 3'd0, 1'b0, 3'd0);
    cyc(8'b0000_0001, 8'b0000_0001, 1'b0, 1'b0);
    chk_mem("b4", 1'b0, 3'd0, 1'b0, 3'd0);
    check("b4.cnt", inflight_cnt, 4'd1);
    cyc(8'b0000_0001, 8'b0000_0001, 1'b0, 1'b0);
    chk_mem("b5", 1'b0, 3'd0, 1'b1, 3'd0);
    cyc(8'h00, 8'h00, 1'b0, 1'b0);
    check("b6.cnt", inflight_cnt, 4'd0);

    // Squash one cycle after issuing ALU 1 and mem 3.
    cyc(8'b0000_1010, 8'b0000_1000, 1'b0, 1'b0);
    chk_alu("s0", 1'b1, 3'd1, 1'b0, 3'd0);
    chk_mem("s0", 1'b1, 3'd3, 1'b0, 3'd0);
    cyc(8'b0000_1010, 8'b0000_1000, 1'b0, 1'b1);
    check("s1.alu_iv", alu_issue_valid, 1'b0);
    check("s1.mem_iv", mem_issue_valid, 1'b0);
    check("s1.cnt", inflight_cnt, 4'd2);
    cyc(8'b0000_1000, 8'b0000_1000, 1'b0, 1'b0);
    check("s2.alu_wv", alu_wb_valid, 1'b0);
    check("s2.mem_wv", mem_wb_valid, 1'b0);
    check("s2.cnt", inflight_cnt, 4'd0);
    chk_mem("s2", 1'b1, 3'd3, 1'b0, 3'd0);
    cyc(8'b0000_1000, 8'b0000_1000, 1'b0, 1'b0);
    chk_mem("s3", 1'b0, 3'd0, 1'b0, 3'd0);
    check("s3.cnt", inflight_cnt, 4'd1);
    cyc(8'b0000_1000, 8'b0000_1000, 1'b0, 1'b0);
    chk_mem("s4", 1'b0, 3'd0, 1'b1, 3'd3);
    cyc(8'h00, 8'h00, 1'b0, 1'b0);
    check("s5.cnt", inflight_cnt, 4'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rob_issue_sched.md
Name: rob_issue_sched

Overview:
- Out-of-order issue scheduler between the ROB entry state and the execution resources.
- Replaces "execute every READY entry at once" with arbitration for two shared resources:
  - one single-cycle ALU;
  - one pipelined data-memory read port with fixed latency MEM_LAT.
- Selects oldest-first relative to the ROB head.
- Tracks in-flight entries and returns writeback strobes (entry index) that move ROB entries to FINISHED.

Parameters:
- ROB_SIZE, 8, number of ROB entries; power of two.
- ROB_SIZE_LOG, 3, log2(ROB_SIZE).
- MEM_LAT, 2, memory read latency in cycles from issue to writeback; legal range 1..4.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- squash  in  1  commit-stage squash (C_valid && C_squash); flushes all scheduler state.
- rob_head  in  ROB_SIZE_LOG  current ROB head; oldest entry.
- ready_vec  in  ROB_SIZE  bit i = entry i is READY (operands available).
- is_mem_vec  in  ROB_SIZE  bit i = entry i needs the data-memory port (ROB_mem_valid).
- mem_port_busy  in  1  external hold; no memory issue while high.
- alu_issue_valid  out  1  ALU issue this cycle (combinational).
- alu_issue_idx  out  ROB_SIZE_LOG  ROB index issued to ALU.
- mem_issue_valid  out  1  memory issue this cycle (combinational).
- mem_issue_idx  out  ROB_SIZE_LOG  ROB index issued to memory port.
- alu_wb_valid  out  1  ALU result for alu_wb_idx (registered).
- alu_wb_idx  out  ROB_SIZE_LOG  entry completing on ALU.
- mem_wb_valid  out  1  memory result for mem_wb_idx (registered).
- mem_wb_idx  out  ROB_SIZE_LOG  entry completing on memory port.
- inflight_cnt  out  ROB_SIZE_LOG+1  number of entries issued but not yet written back.

Behaviour:
- State:
  - issued[ROB_SIZE] mask.
  - alu_wb register: 1 stage.
  - mem shift pipe: MEM_LAT stages of {valid, idx}.
  - inflight_cnt register.
- Reset: all state is 0. All outputs are 0, including idx outputs.
- Candidate sets:
  - alu_cand = ready_vec & ~issued & ~is_mem_vec.
  - mem_cand = ready_vec & ~issued & is_mem_vec.
- Selection, per resource:
  - Pick the candidate with minimum age, where age(i) = (i - rob_head) mod ROB_SIZE, computed in ROB_SIZE_LOG bits so it wraps naturally.
  - Ties are impossible because ages are unique.
- Issue:
  - alu_issue_valid = |alu_cand and !squash.
  - mem_issue_valid = |mem_cand and !squash and !mem_port_busy.
  - Both may fire in the same cycle.
  - At the issue edge, the issued bit of each issued index is set.
- ALU latency:
  - Issue in cycle t gives alu_wb_valid = 1 with the same idx in cycle t+1.
  - alu_wb is deasserted in the following cycle unless a new issue occurred.
- Memory latency:
  - Issue in cycle t gives mem_wb_valid in cycle t+MEM_LAT.
  - Fully pipelined: one issue per cycle is accepted regardless of in-flight count.
- Writeback clear:
  - At the edge ending a cycle with x_wb_valid, issued[x_wb_idx] clears.
  - The ROB marks the entry FINISHED on the same edge, so ready_vec drops and no reissue occurs.
- Same-index set and clear on one edge cannot occur for a correct ROB (the entry is FINISHED first). If it does occur, set wins.
- inflight_cnt changes by +issues − writebacks each cycle, so the net change is in −2..+2.
- Squash:
  - In the squash cycle, no issue occurs.
  - At that edge, issued, alu_wb and every mem pipe stage clear, and inflight_cnt clears.
  - wb outputs visible during the squash cycle are stale; the ROB ignores them because squash has priority.
  - From the next cycle, all outputs are 0.
- rst mid-operation behaves identically to squash.
- mem_port_busy:
  - Blocks memory issue only.
  - ALU issue and in-flight memory stages continue to advance.
- Empty (no candidates): issue_valid = 0 and idx = 0.

Decomposition:
- Shared package `ooo_pkg` holds ROB_SIZE, ROB_SIZE_LOG, and MEM_LAT defaults, alongside the existing ROB state encodings (IDLE/STALLED/READY/FINISHED).
- One sub-module, `age_picker`:
  - inputs: req vector, head;
  - outputs: valid, idx;
  - selects the oldest set bit by rotating the vector by head and applying a priority encode.
  - Instantiated twice, once for the ALU and once for memory.

Test Plan:
- Head = 0; ready_vec = 8'b0000_0110; is_mem_vec = 0:
  - cycle 0: alu_issue_idx = 1;
  - cycle 1: alu_wb idx 1 and alu_issue_idx = 2;
  - cycle 2: alu_wb idx 2.
- Wrap-around: head = 6; ALU candidates at 1 and 7 → issue 7 first, then 1.
- MEM_LAT = 2; mem candidates at 3 and 4; head = 0:
  - issues in cycles 0 and 1;
  - mem_wb idx 3 in cycle 2, idx 4 in cycle 3;
  - inflight_cnt peaks at 2.
- Mixed: entry 2 is ALU and entry 5 is mem, both ready → both issue in cycle 0; alu_wb in cycle 1; mem_wb in cycle 2.
- mem_port_busy held high for 3 cycles with mem candidate 0 → no mem issue; issue occurs the cycle busy drops; wb follows MEM_LAT later.
- Squash one cycle after issuing mem idx 3 and ALU idx 1 → next cycle mem_wb_valid = 0, alu_wb_valid = 0, inflight_cnt = 0; entry 3 becomes reissuable when ready again.
